// File: rtl/mux_arb_n_bit_pkg.sv
// Shared constants, mode encoding and index helper for the N-channel registered selector.
package mux_arb_n_bit_pkg;

    typedef enum logic {
        MUX_MODE_FIXED = 1'b0,
        MUX_MODE_RR    = 1'b1
    } mux_mode_e;

    // Channel reached by stepping 'offset' places past 'base', wrapping at n.
    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/mux_arb_n_bit_if.sv
// Producer/consumer handshake bundle around the selector; slave is the selector side.
interface mux_arb_n_bit_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [SEL_W-1:0]          select;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic [SEL_W-1:0]          out_channel;
    logic                      out_ready;

    modport master (
        output in_data, in_valid, select, out_ready,
        input  in_ready, out_data, out_valid, out_channel
    );

    modport slave (
        input  in_data, in_valid, select, out_ready,
        output in_ready, out_data, out_valid, out_channel
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester strictly after ptr, wrapping modulo CHANNELS.
// Latency: purely combinational.
// Backpressure: none; the caller gates the grant with its own load enable.
module rr_arbiter
    import mux_arb_n_bit_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [SEL_W-1:0]    grant,
    output logic                grant_valid
);

    always_comb begin
        logic [SEL_W-1:0] idx;
        idx         = '0;
        grant       = '0;
        grant_valid = 1'b0;
        // Walk from the farthest candidate back to the nearest so the nearest wins.
        for (int k = CHANNELS; k >= 1; k--) begin
            idx = SEL_W'(rr_index(int'(ptr), k, CHANNELS));
            if (req[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_n_bit.sv
// N-channel registered word selector, fixed-select or round-robin, valid/ready on all sides.
// Latency: 1 cycle from input transfer to out_valid; 1 word/cycle with drain and load on one edge.
// Backpressure: one-entry output buffer; while it is full and out_ready is low, all in_ready drop.
module mux_arb_n_bit
    import mux_arb_n_bit_pkg::*;
#(
    parameter int        WIDTH    = 32,
    parameter int        CHANNELS = 4,
    parameter mux_mode_e MODE     = MUX_MODE_FIXED
) (
    input logic            clk,
    input logic            rst,
    mux_arb_n_bit_if.slave bus
);

    localparam int SEL_W = $clog2(CHANNELS);
    localparam int PAD_N = 1 << SEL_W;

    logic                   w_load_en;
    logic                   w_in_xfer;
    logic                   w_grant_vld;
    logic [SEL_W-1:0]       w_grant;
    logic                   w_fix_vld;
    logic                   w_rr_vld;
    logic [SEL_W-1:0]       w_rr_grant;
    logic [PAD_N-1:0]       w_vld_pad;
    logic [PAD_N*WIDTH-1:0] w_data_pad;
    logic [CHANNELS-1:0]    w_in_ready;

    logic [WIDTH-1:0]       r_data;
    logic                   r_vld;
    logic [SEL_W-1:0]       r_ch;
    logic [SEL_W-1:0]       r_ptr;

    // Padding to a power of two keeps an out-of-range select from indexing past the bus.
    assign w_vld_pad  = PAD_N'(bus.in_valid);
    assign w_data_pad = (PAD_N*WIDTH)'(bus.in_data);
    assign w_fix_vld  = (int'(bus.select) < CHANNELS) && w_vld_pad[bus.select];

    rr_arbiter #(.CHANNELS(CHANNELS)) u_rr_arbiter (
        .req         (bus.in_valid),
        .ptr         (r_ptr),
        .grant       (w_rr_grant),
        .grant_valid (w_rr_vld)
    );

    assign w_grant     = (MODE == MUX_MODE_RR) ? w_rr_grant : bus.select;
    assign w_grant_vld = (MODE == MUX_MODE_RR) ? w_rr_vld   : w_fix_vld;

    assign w_load_en = !r_vld || bus.out_ready;
    assign w_in_xfer = !rst && w_load_en && w_grant_vld;

    always_comb begin
        w_in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_in_xfer && (int'(w_grant) == i)) begin
                w_in_ready[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_vld  <= 1'b0;
            r_ch   <= '0;
            r_ptr  <= SEL_W'(CHANNELS - 1);
        end else if (w_in_xfer) begin
            r_data <= w_data_pad[int'(w_grant)*WIDTH +: WIDTH];
            r_vld  <= 1'b1;
            r_ch   <= w_grant;
            if (MODE == MUX_MODE_RR) begin
                r_ptr <= w_grant;
            end
        end else if (r_vld && bus.out_ready) begin
            r_vld <= 1'b0;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_data    = r_data;
    assign bus.out_valid   = r_vld;
    assign bus.out_channel = r_ch;

endmodule
